// File: rtl/ramio_cmd_initiator.sv
// ramio_cmd_initiator: byte-stream command interpreter driving the ramio client bus (optional WAIT timeout via RAMIO_CMD_TIMEOUT_EN)
module ramio_cmd_initiator #(
  parameter int AddressBitWidth = 32,
  parameter int DataBitWidth    = 32,
  parameter int TimeoutCycles   = 65535
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 cmd_data,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  output logic [7:0]                 rsp_data,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic                       mem_enable,
  output logic [2:0]                 mem_read_type,
  output logic [1:0]                 mem_write_type,
  output logic [AddressBitWidth-1:0] mem_address,
  output logic [DataBitWidth-1:0]    mem_data_out,
  input  logic [DataBitWidth-1:0]    mem_data_in,
  input  logic                       mem_data_in_ready,
  input  logic                       mem_busy,
  output logic                       timeout
);
  localparam logic [7:0] OpW = 8'h57, OpB = 8'h42, OpR = 8'h52, OpRb = 8'h62;
  localparam logic [7:0] Ack = 8'h06, Nak = 8'h15, Can = 8'h18;
  typedef enum logic [2:0] {IDLE, ADDR, DATA, ISSUE, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic live, act, cmd_fire, rsp_fire, op_ok, is_write, is_word, misalign, done, tmo;
  logic [7:0] op;
  logic [31:0] addr, wdata, rbuf;
  logic [1:0] idx, rsp_last;
  assign cmd_fire = cmd_valid && cmd_ready;
  assign rsp_fire = rsp_valid && rsp_ready;
  assign op_ok = cmd_data inside {OpW, OpB, OpR, OpRb};
  assign is_write = op == OpW || op == OpB;
  assign is_word = op == OpW || op == OpR;
  assign misalign = is_word && addr[1:0] != 2'b00;
  assign done = state == WAIT && !mem_busy && (is_write || mem_data_in_ready);
`ifdef RAMIO_CMD_TIMEOUT_EN
  logic [15:0] tcnt;
  logic timeout_q;
  assign tmo = state == WAIT && !done && tcnt == 16'(TimeoutCycles - 1);
  assign timeout = timeout_q;
  // count WAIT cycles; the timeout flag is sticky until reset
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tcnt <= '0;
      timeout_q <= 1'b0;
    end else begin
      tcnt <= state == WAIT ? tcnt + 16'd1 : '0;
      timeout_q <= timeout_q | tmo;
    end
`else
  assign tmo = 1'b0;
  assign timeout = 1'b0;
`endif
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // packet sequencing: opcode, address, optional data, bus request, response
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (cmd_fire) state_nx = op_ok ? ADDR : RESP;
      ADDR:  if (cmd_fire && idx == 2'd3) state_nx = is_write ? DATA : misalign ? RESP : ISSUE;
      DATA:  if (cmd_fire && idx == (is_word ? 2'd3 : 2'd0)) state_nx = misalign ? RESP : ISSUE;
      ISSUE: state_nx = WAIT;
      WAIT:  if (done || tmo) state_nx = RESP;
      RESP:  if (rsp_fire && idx == rsp_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // handshake and bus outputs; the request is held from ISSUE through WAIT
  always_comb begin
    act = state == ISSUE || state == WAIT;
    cmd_ready = live && (state == IDLE || state == ADDR || state == DATA);
    rsp_valid = state == RESP;
    rsp_data = rsp_valid ? rbuf[{idx, 3'b000} +: 8] : 8'h00;
    mem_enable = act;
    mem_read_type = act && !is_write ? (is_word ? 3'b111 : 3'b001) : 3'b000;
    mem_write_type = act && is_write ? (is_word ? 2'b11 : 2'b01) : 2'b00;
    mem_address = act ? AddressBitWidth'(addr) : '0;
    mem_data_out = act && is_write ? DataBitWidth'(wdata) : '0;
  end
  // byte assembly, response loading and the shared byte index
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      live <= 1'b0;
      op <= '0;
      addr <= '0;
      wdata <= '0;
      rbuf <= '0;
      idx <= '0;
      rsp_last <= '0;
    end else begin
      live <= 1'b1;
      idx <= state_nx != state ? 2'd0 : (cmd_fire || rsp_fire) ? idx + 2'd1 : idx;
      if (state == IDLE && cmd_fire) begin
        op <= cmd_data;
        wdata <= '0;
      end
      if (state == ADDR && cmd_fire) addr[{idx, 3'b000} +: 8] <= cmd_data;
      if (state == DATA && cmd_fire) wdata[{idx, 3'b000} +: 8] <= cmd_data;
      if (state_nx == RESP && state != RESP) begin
        rbuf <= state != WAIT ? {24'h0, Nak} : tmo ? {24'h0, Can} : is_write ? {24'h0, Ack} :
                is_word ? 32'(mem_data_in) : {24'h0, mem_data_in[7:0]};
        rsp_last <= state == WAIT && done && !is_write && is_word ? 2'd3 : 2'd0;
      end
    end
endmodule
